lcd_ctrl: RTL and testbench



---
 rtl/lcd_ctrl.sv | 153 +++++++++++++++
 tb/tb_lcd_ctrl.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/lcd_ctrl.sv
// HD44780-style 8-bit write-only LCD bus sequencer: power-up wait, fixed init sequence,
// then one command/data byte per valid/ready handshake with cycle-counted bus timing.
module lcd_ctrl #(
   parameter int unsigned POWERUP_CYC   = 750000,
   parameter int unsigned SETUP_CYC     = 4,
   parameter int unsigned PULSE_CYC     = 12,
   parameter int unsigned HOLD_CYC      = 4,
   parameter int unsigned EXEC_CYC      = 2000,
   parameter int unsigned LONG_EXEC_CYC = 82000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   input  logic       cmd_rs,
   input  logic [7:0] cmd_data,
   output logic       cmd_ready,
   output logic       busy,
   output logic       init_done,
   output logic [7:0] lcd_data,
   output logic       lcd_rs,
   output logic       lcd_rw,
   output logic       lcd_en,
   output logic       lcd_on
);

   typedef enum logic [2:0] {
      StPwrup,
      StSetup,
      StPulse,
      StHold,
      StExec,
      StIdle
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] cnt_q, cnt_d;
   logic [1:0]  idx_q, idx_d;
   logic [7:0]  data_q, data_d;
   logic        rs_q, rs_d;
   logic        init_done_q, init_done_d;
   logic        en_q;
   logic        on_q;
   logic        long_exec;

   function automatic logic [7:0] init_byte(input logic [1:0] i);
      logic [7:0] b;
      unique case (i)
         2'd0:    b = 8'h38;
         2'd1:    b = 8'h0C;
         2'd2:    b = 8'h01;
         default: b = 8'h06;
      endcase
      return b;
   endfunction

   // Clear and home need the long execution wait.
   assign long_exec = !rs_q && ((data_q == 8'h01) || (data_q[7:1] == 7'b0000001));

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q - 32'd1;
      idx_d       = idx_q;
      data_d      = data_q;
      rs_d        = rs_q;
      init_done_d = init_done_q;
      unique case (state_q)
         StPwrup: begin
            if (cnt_q == 32'd0) begin
               data_d  = init_byte(2'd0);
               rs_d    = 1'b0;
               state_d = StSetup;
               cnt_d   = SETUP_CYC - 1;
            end
         end
         StSetup: begin
            if (cnt_q == 32'd0) begin
               state_d = StPulse;
               cnt_d   = PULSE_CYC - 1;
            end
         end
         StPulse: begin
            if (cnt_q == 32'd0) begin
               state_d = StHold;
               cnt_d   = HOLD_CYC - 1;
            end
         end
         StHold: begin
            if (cnt_q == 32'd0) begin
               state_d = StExec;
               cnt_d   = long_exec ? LONG_EXEC_CYC - 1 : EXEC_CYC - 1;
            end
         end
         StExec: begin
            if (cnt_q == 32'd0) begin
               if (init_done_q) begin
                  state_d = StIdle;
               end else if (idx_q == 2'd3) begin
                  state_d     = StIdle;
                  init_done_d = 1'b1;
               end else begin
                  idx_d   = idx_q + 2'd1;
                  data_d  = init_byte(idx_q + 2'd1);
                  rs_d    = 1'b0;
                  state_d = StSetup;
                  cnt_d   = SETUP_CYC - 1;
               end
            end
         end
         default: begin
            cnt_d = cnt_q;
            if (cmd_valid) begin
               data_d  = cmd_data;
               rs_d    = cmd_rs;
               state_d = StSetup;
               cnt_d   = SETUP_CYC - 1;
            end
         end
      endcase
   end

   // Reset loads the full power-up count: the edge that first sees rst low starts cycle 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StPwrup;
         cnt_q       <= POWERUP_CYC;
         idx_q       <= 2'd0;
         data_q      <= 8'h00;
         rs_q        <= 1'b0;
         init_done_q <= 1'b0;
         en_q        <= 1'b0;
         on_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         data_q      <= data_d;
         rs_q        <= rs_d;
         init_done_q <= init_done_d;
         en_q        <= (state_d == StPulse);
         on_q        <= 1'b1;
      end
   end

   assign cmd_ready = (state_q == StIdle);
   assign busy      = (state_q != StIdle);
   assign init_done = init_done_q;
   assign lcd_data  = data_q;
   assign lcd_rs    = rs_q;
   assign lcd_rw    = 1'b0;
   assign lcd_en    = en_q;
   assign lcd_on    = on_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Directed bench for lcd_ctrl: init timing, command latency, long-exec decode,
// back-to-back traffic, valid during init and reset mid-pulse.
module tb_lcd_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       cmd_valid;
   logic       cmd_rs;
   logic [7:0] cmd_data;
   logic       cmd_ready;
   logic       busy;
   logic       init_done;
   logic [7:0] lcd_data;
   logic       lcd_rs;
   logic       lcd_rw;
   logic       lcd_en;
   logic       lcd_on;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   lcd_ctrl #(
      .POWERUP_CYC  (10),
      .SETUP_CYC    (2),
      .PULSE_CYC    (3),
      .HOLD_CYC     (2),
      .EXEC_CYC     (5),
      .LONG_EXEC_CYC(20)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .cmd_valid(cmd_valid),
      .cmd_rs   (cmd_rs),
      .cmd_data (cmd_data),
      .cmd_ready(cmd_ready),
      .busy     (busy),
      .init_done(init_done),
      .lcd_data (lcd_data),
      .lcd_rs   (lcd_rs),
      .lcd_rw   (lcd_rw),
      .lcd_en   (lcd_en),
      .lcd_on   (lcd_on)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One reset edge, then check every output's reset value.
   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      chk("rst_en", lcd_en, 1'b0);
      chk("rst_on", lcd_on, 1'b0);
      chk("rst_done", init_done, 1'b0);
      chk("rst_ready", cmd_ready, 1'b0);
      chk("rst_busy", busy, 1'b1);
      chk("rst_data", lcd_data, 8'h00);
      chk("rst_rs", lcd_rs, 1'b0);
      chk("rst_rw", lcd_rw, 1'b0);
   endtask

   // Releases reset and checks cycles 0..73; returns at the sample point of cycle 73.
   task automatic init_check();
      rst = 1'b0;
      @(negedge clk);
      for (int c = 0; c <= 73; c++) begin
         logic       e;
         logic [7:0] b;
         e = (c >= 12 && c <= 14) || (c >= 24 && c <= 26) ||
             (c >= 36 && c <= 38) || (c >= 63 && c <= 65);
         b = (c <= 14) ? 8'h38 : (c <= 26) ? 8'h0C : (c <= 38) ? 8'h01 : 8'h06;
         chk("init_on", lcd_on, 1'b1);
         chk("init_en", lcd_en, e);
         chk("init_busy", busy, c < 73);
         chk("init_done", init_done, c >= 73);
         chk("init_ready", cmd_ready, c >= 73);
         chk("init_rw", lcd_rw, 1'b0);
         if (e) begin
            chk("init_data", lcd_data, b);
            chk("init_rs", lcd_rs, 1'b0);
         end
         if (c < 73) @(negedge clk);
      end
   endtask

   // Called at cycle T in IDLE; ret is the cycle offset where cmd_ready must return.
   // hold keeps cmd_valid high with scrambled inputs while busy.
   task automatic send(input logic rs, input logic [7:0] d, input int ret, input logic hold);
      int pulses;
      chk("send_ready", cmd_ready, 1'b1);
      cmd_valid = 1'b1;
      cmd_rs    = rs;
      cmd_data  = d;
      @(negedge clk);
      cmd_valid = hold;
      cmd_rs    = ~rs;
      cmd_data  = ~d;
      pulses    = 0;
      for (int k = 1; k <= ret; k++) begin
         chk("tx_data", lcd_data, d);
         chk("tx_rs", lcd_rs, rs);
         chk("tx_en", lcd_en, k >= 3 && k <= 5);
         chk("tx_rw", lcd_rw, 1'b0);
         chk("tx_ready", cmd_ready, k == ret);
         chk("tx_busy", busy, k != ret);
         if (lcd_en) pulses++;
         if (k < ret) @(negedge clk);
      end
      chk("tx_pulses", pulses, 3);
   endtask

   initial begin
      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_rs    = 1'b0;
      cmd_data  = 8'h00;
      @(negedge clk);

      do_reset();
      init_check();

      send(1'b1, 8'h41, 13, 1'b0);
      send(1'b0, 8'h01, 28, 1'b0);
      send(1'b0, 8'h03, 28, 1'b0);
      send(1'b0, 8'h02, 28, 1'b0);
      send(1'b1, 8'h01, 13, 1'b0);
      send(1'b0, 8'h38, 13, 1'b0);

      send(1'b1, 8'h48, 13, 1'b1);
      send(1'b1, 8'h49, 13, 1'b1);
      send(1'b1, 8'h4A, 13, 1'b0);

      // Valid held through init must not disturb the init bytes.
      cmd_valid = 1'b1;
      cmd_rs    = 1'b1;
      cmd_data  = 8'h55;
      do_reset();
      init_check();
      send(1'b1, 8'h55, 13, 1'b0);

      // Reset while EN is high in a data write.
      cmd_valid = 1'b1;
      cmd_rs    = 1'b1;
      cmd_data  = 8'h41;
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("mid_en", lcd_en, 1'b1);
      do_reset();
      init_check();
      send(1'b1, 8'h41, 13, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
